// File: rtl/compare_neighbor_pkg.sv
// compare_neighbor_pkg
// Shared constants for the 3x3 local-maximum decision cell.
//   WIDTH_DEF     : default unsigned sample width
//   NUM_NEIGHBORS : neighbours compared against the centre sample
package compare_neighbor_pkg;

  localparam int WIDTH_DEF     = 8;
  localparam int NUM_NEIGHBORS = 8;

endpackage

// File: rtl/compare_neighbor_if.sv
// compare_neighbor_if
// Bundle of the data seen by one decision cell: centre sample, the eight
// neighbour samples, the neighbours' current local-max flags, and the
// cell's registered flag.
//   master : drives centre/nb/res, observes flag (pixel array / bench side)
//   slave  : consumes centre/nb/res, produces flag (decision cell side)
interface compare_neighbor_if
  import compare_neighbor_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic [WIDTH-1:0]         centre;
  logic [WIDTH-1:0]         nb [NUM_NEIGHBORS];
  logic [NUM_NEIGHBORS-1:0] res;
  logic                     flag;

  modport master (output centre, output nb, output res, input flag);
  modport slave  (input centre, input nb, input res, output flag);

endinterface

// File: rtl/compare_neighbor_cmp.sv
// neighbor_cmp
// Pass term for one neighbour of the centre sample.
//   centre_i    : centre sample, unsigned
//   neighbour_i : neighbour sample, unsigned
//   res_i       : neighbour's current local-max flag
//   ok_o        : 1 when this neighbour does not disqualify the centre
module neighbor_cmp
  import compare_neighbor_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] centre_i,
  input  logic [WIDTH-1:0] neighbour_i,
  input  logic             res_i,
  output logic             ok_o
);

  // On a tie the centre inherits the neighbour's status, which is what lets
  // plateau non-maximality spread across iterations of the array.
  assign ok_o = (centre_i > neighbour_i) || ((centre_i == neighbour_i) && res_i);

endmodule

// File: rtl/compare_neighbor.sv
// compare_neighbor
// Plateau-aware local-maximum flag for one pixel of a 3x3 neighbourhood.
//   clk          : system clock, rising edge
//   in           : centre sample
//   in_1..in_8   : neighbour samples (order carries no meaning)
//   res_1..res_8 : neighbours' current local-max flags
//   out          : registered local-max flag, 1 cycle after inputs
//   rst          : synchronous active-high reset, clears out
// Port names and order are fixed by the surrounding pixel array, which
// connects cells positionally; rst is appended last.
module compare_neighbor
  import compare_neighbor_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] in,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic [WIDTH-1:0] in_3,
  input  logic [WIDTH-1:0] in_4,
  input  logic [WIDTH-1:0] in_5,
  input  logic [WIDTH-1:0] in_6,
  input  logic [WIDTH-1:0] in_7,
  input  logic [WIDTH-1:0] in_8,
  input  logic             res_1,
  input  logic             res_2,
  input  logic             res_3,
  input  logic             res_4,
  input  logic             res_5,
  input  logic             res_6,
  input  logic             res_7,
  input  logic             res_8,
  output logic             out,
  input  logic             rst
);

  logic [WIDTH-1:0]         nb [NUM_NEIGHBORS];
  logic [NUM_NEIGHBORS-1:0] res_v;
  logic [NUM_NEIGHBORS-1:0] ok;
  logic                     out_d;
  logic                     out_q;

  assign nb[0] = in_1;
  assign nb[1] = in_2;
  assign nb[2] = in_3;
  assign nb[3] = in_4;
  assign nb[4] = in_5;
  assign nb[5] = in_6;
  assign nb[6] = in_7;
  assign nb[7] = in_8;

  assign res_v = {res_8, res_7, res_6, res_5, res_4, res_3, res_2, res_1};

  for (genvar g = 0; g < NUM_NEIGHBORS; g++) begin : g_cmp
    neighbor_cmp #(.WIDTH(WIDTH)) u_cmp (
      .centre_i    (in),
      .neighbour_i (nb[g]),
      .res_i       (res_v[g]),
      .ok_o        (ok[g])
    );
  end

  assign out_d = &ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= 1'b0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_compare_neighbor.sv
module tb_compare_neighbor;
  import compare_neighbor_pkg::*;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  compare_neighbor_if #(.WIDTH(8)) ifc ();

  compare_neighbor #(.WIDTH(8)) dut (
    .clk   (clk),
    .in    (ifc.centre),
    .in_1  (ifc.nb[0]),
    .in_2  (ifc.nb[1]),
    .in_3  (ifc.nb[2]),
    .in_4  (ifc.nb[3]),
    .in_5  (ifc.nb[4]),
    .in_6  (ifc.nb[5]),
    .in_7  (ifc.nb[6]),
    .in_8  (ifc.nb[7]),
    .res_1 (ifc.res[0]),
    .res_2 (ifc.res[1]),
    .res_3 (ifc.res[2]),
    .res_4 (ifc.res[3]),
    .res_5 (ifc.res[4]),
    .res_6 (ifc.res[5]),
    .res_7 (ifc.res[6]),
    .res_8 (ifc.res[7]),
    .out   (ifc.flag),
    .rst   (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: a centre is a maximum unless some neighbour is larger, or some
  // equal neighbour has already been declared non-maximal.
  function automatic logic ref_max(input logic [7:0] c, input logic [63:0] nbv,
                                   input logic [7:0] rs);
    for (int k = 0; k < 8; k++) begin
      if (c < nbv[8*k +: 8]) return 1'b0;
      if (c == nbv[8*k +: 8] && !rs[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  logic [63:0] nb_pack;
  always_comb begin
    nb_pack = '0;
    for (int k = 0; k < 8; k++) nb_pack[8*k +: 8] = ifc.nb[k];
  end

  logic exp_q;
  logic exp_valid;
  initial exp_valid = 1'b0;

  always @(posedge clk) begin
    exp_q     <= rst ? 1'b0 : ref_max(ifc.centre, nb_pack, ifc.res);
    exp_valid <= 1'b1;
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (exp_valid) begin
      n_total = n_total + 1;
      if (ifc.flag === exp_q) n_pass = n_pass + 1;
      else $display("FAIL model_cmp t=%0t out=%b expected=%b", $time, ifc.flag, exp_q);
    end
  end

  task automatic apply(input logic r, input logic [7:0] c, input logic [63:0] nbv,
                       input logic [7:0] rs);
    rst        = r;
    ifc.centre = c;
    for (int k = 0; k < 8; k++) ifc.nb[k] = nbv[8*k +: 8];
    ifc.res    = rs;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic expv);
    n_total = n_total + 1;
    if (ifc.flag === expv) n_pass = n_pass + 1;
    else $display("FAIL %s out=%b expected=%b", name, ifc.flag, expv);
  endtask

  localparam logic [63:0] NB_K    = 64'h0807_0605_0403_0201;
  localparam logic [63:0] NB_TIE5 = 64'h0505_0505_0403_0201;
  localparam logic [63:0] NB_ALLF = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] NB_ALLE = 64'hFEFE_FEFE_FEFE_FEFE;
  localparam logic [63:0] NB_IN3  = 64'h0000_0000_0001_0000;

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    ifc.centre = '0;
    for (int k = 0; k < 8; k++) ifc.nb[k] = '0;
    ifc.res = '0;
    #1;

    apply(1'b1, 8'd8, NB_K, 8'hFF);      chk("reset_c1", 1'b0);
    apply(1'b1, 8'd8, NB_K, 8'hFF);      chk("reset_c2", 1'b0);
    apply(1'b0, 8'd8, NB_K, 8'hFF);      chk("reset_release", 1'b1);

    apply(1'b0, 8'd0, NB_K, 8'hFF);      chk("dominated_0", 1'b0);
    apply(1'b0, 8'd4, NB_K, 8'hFF);      chk("dominated_4", 1'b0);

    apply(1'b0, 8'd8, NB_K, 8'hFF);      chk("tie_allowed", 1'b1);
    apply(1'b0, 8'd8, NB_K, 8'h7F);      chk("tie_res8_clear", 1'b0);

    apply(1'b0, 8'd8, NB_TIE5, 8'h7F);   chk("greater_ignores_res", 1'b1);
    apply(1'b0, 8'd5, NB_TIE5, 8'h7F);   chk("plateau_clear", 1'b0);
    apply(1'b0, 8'd5, NB_TIE5, 8'hFF);   chk("plateau_set", 1'b1);

    apply(1'b0, 8'd255, NB_ALLF, 8'hFF); chk("max_all_equal", 1'b1);
    apply(1'b0, 8'd255, NB_ALLF, 8'hFB); chk("max_res3_clear", 1'b0);
    apply(1'b0, 8'd255, NB_ALLE, 8'h00); chk("max_over_254", 1'b1);
    apply(1'b0, 8'd0, NB_IN3, 8'hFF);    chk("zero_vs_one", 1'b0);
    apply(1'b0, 8'd0, 64'd0, 8'hFF);     chk("zero_all_zero", 1'b1);
    apply(1'b1, 8'd0, 64'd0, 8'hFF);     chk("reset_priority", 1'b0);

    // Random: narrow value range so ties and plateaus occur often.
    for (int i = 0; i < 400; i++) begin
      logic [63:0] nbv;
      logic [7:0]  c;
      logic        wide;
      wide = ($urandom_range(0, 7) == 0);
      c = wide ? 8'($urandom) : 8'($urandom_range(0, 3));
      for (int k = 0; k < 8; k++)
        nbv[8*k +: 8] = wide ? 8'($urandom) : 8'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        for (int k = 0; k < 8; k++) if (nbv[8*k +: 8] > c) nbv[8*k +: 8] = c;
      end
      apply(($urandom_range(0, 31) == 0), c, nbv, 8'($urandom));
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
